fetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the IF_ID pipeline register.
- Generates the word-address PC and issues pipelined requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned instructions, with their PCs, in a small FIFO that decode drains via valid/ready; the decode-side ready is the hazard unit's IF_ID_write.
- A redirect input (branch/jump resolution) flushes the queue and discards in-flight responses.

---
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch stage that issues pipelined imem requests and
//            buffers in-order responses, with their PCs, for decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int                ADDR_W   = 7,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_ins,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] C_FULL = (CW+1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    cnt_t              count_q, count_d;
    cnt_t              outst_q, outst_d;
    cnt_t              discard_q, discard_d;
    ptr_t              wr_q, wr_d, rd_q, rd_d;
    ptr_t              tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [31:0]       ins_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
    logic [ADDR_W-1:0] tag_mem_q [DEPTH];

    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_keep;
    logic              pop;
    logic [CW:0]       inflight_sum;

    // Queued entries plus in-flight requests (including ones to be discarded)
    // must fit in the queue, so every response always has a slot.
    assign inflight_sum   = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req_valid = !rst && !redirect_valid && (inflight_sum < C_FULL);
    assign imem_req_addr  = pc_q;

    assign id_valid = (count_q != '0) && !redirect_valid && !rst;
    assign id_ins   = id_valid ? ins_mem_q[rd_q] : '0;
    assign id_pc    = id_valid ? pc_mem_q[rd_q]  : '0;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (outst_q != '0);
    assign rsp_keep = rsp_fire && (discard_q == '0) && !redirect_valid;
    assign pop      = id_valid && id_ready;

    always_comb begin
        pc_d      = pc_q;
        count_d   = count_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        if (redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old path.
            pc_d      = redirect_pc;
            count_d   = '0;
            wr_d      = '0;
            rd_d      = '0;
            tag_wr_d  = '0;
            tag_rd_d  = '0;
            outst_d   = outst_q - cnt_t'(rsp_fire);
            discard_d = outst_q - cnt_t'(rsp_fire);
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + 1'b1;
                tag_wr_d = tag_wr_q + 1'b1;
            end
            outst_d = outst_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (rsp_keep) begin
                wr_d     = wr_q + 1'b1;
                tag_rd_d = tag_rd_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            count_d = count_q + cnt_t'(rsp_keep) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
        end
    end

    // Storage arrays carry no reset; occupancy is governed by the counters.
    always_ff @(posedge clk) begin
        if (!rst && req_fire) begin
            tag_mem_q[tag_wr_q] <= pc_q;
        end
        if (!rst && rsp_keep) begin
            ins_mem_q[wr_q] <= imem_rsp_data;
            pc_mem_q[wr_q]  <= tag_mem_q[tag_rd_q];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed and randomized bench for fetch_queue using a
//            transaction-level reference model and an in-order memory model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_queue;

    localparam int         ADDR_W = 7;
    localparam int         DEPTH  = 4;
    localparam logic [6:0] RST_PC = 7'h7E;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [6:0]  imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_ins;
    logic [6:0]  id_pc;
    logic        redirect_valid = 1'b0;
    logic [6:0]  redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ins         (id_ins),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct { logic [6:0] addr; logic stale; } infl_t;
    typedef struct { logic [6:0] pc; logic [31:0] ins; } ent_t;
    typedef struct { logic [6:0] addr; int due; } pend_t;

    // Reference model: requests in flight, decoded-side queue, next PC.
    infl_t      m_infl[$];
    ent_t       m_fifo[$];
    logic [6:0] m_pc;
    // Memory model: pending in-order responses and backing store.
    pend_t       mem_pend[$];
    logic [31:0] mem_word [128];
    logic [6:0]  popped[$];

    int cyc    = 0;
    int lat    = 1;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        rsp_v, e_rv, e_iv, dut_fire;
        logic [6:0]  e_idpc, dut_addr;
        logic [31:0] e_ins;
        infl_t       inf;
        ent_t        ent;
        pend_t       p;
        int          d;
        rsp_v = (mem_pend.size() > 0) && (mem_pend[0].due <= cyc);
        imem_rsp_valid = rsp_v;
        if (rsp_v) imem_rsp_data = mem_word[mem_pend[0].addr];
        else       imem_rsp_data = $urandom;
        #1;
        e_rv   = !rst && !redirect_valid && ((m_fifo.size() + m_infl.size()) < DEPTH);
        e_iv   = !rst && !redirect_valid && (m_fifo.size() > 0);
        e_ins  = e_iv ? m_fifo[0].ins : 32'h0;
        e_idpc = e_iv ? m_fifo[0].pc  : 7'h0;
        check("req_valid", 32'(imem_req_valid), 32'(e_rv));
        check("req_addr",  32'(imem_req_addr),  32'(m_pc));
        check("id_valid",  32'(id_valid),       32'(e_iv));
        check("id_ins",    id_ins,              e_ins);
        check("id_pc",     32'(id_pc),          32'(e_idpc));
        check("count_le_depth",   32'(dut.count_q   <= DEPTH), 32'd1);
        check("outst_le_depth",   32'(dut.outst_q   <= DEPTH), 32'd1);
        check("discard_le_depth", 32'(dut.discard_q <= DEPTH), 32'd1);
        if (e_iv && id_ready) popped.push_back(e_idpc);
        dut_fire = imem_req_valid && imem_req_ready;
        dut_addr = imem_req_addr;
        @(posedge clk);
        if (rst) begin
            m_infl.delete();
            m_fifo.delete();
            m_pc = RST_PC;
        end else if (redirect_valid) begin
            if (rsp_v && m_infl.size() > 0) void'(m_infl.pop_front());
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_fifo.delete();
            m_pc = redirect_pc;
        end else begin
            if (e_iv && id_ready) void'(m_fifo.pop_front());
            if (rsp_v && m_infl.size() > 0) begin
                inf = m_infl.pop_front();
                if (!inf.stale) begin
                    ent.pc  = inf.addr;
                    ent.ins = mem_word[inf.addr];
                    m_fifo.push_back(ent);
                end
            end
            if (e_rv && imem_req_ready) begin
                inf.addr  = m_pc;
                inf.stale = 1'b0;
                m_infl.push_back(inf);
                m_pc = m_pc + 7'd1;
            end
        end
        if (rsp_v) void'(mem_pend.pop_front());
        if (dut_fire) begin
            d = cyc + lat;
            if (mem_pend.size() > 0 && mem_pend[$].due >= d) d = mem_pend[$].due + 1;
            p.addr = dut_addr;
            p.due  = d;
            mem_pend.push_back(p);
        end
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        foreach (mem_word[i]) mem_word[i] = $urandom;
        m_pc = RST_PC;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset held: outputs gated; then wrap-around fetch from RESET_PC.
        step();
        rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; lat = 1;
        popped.delete();
        for (int i = 0; i < 8; i++) step();
        check("wrap_count", popped.size() >= 4, 1);
        if (popped.size() >= 4) begin
            check("wrap_pc0", 32'(popped[0]), 32'h7E);
            check("wrap_pc1", 32'(popped[1]), 32'h7F);
            check("wrap_pc2", 32'(popped[2]), 32'h00);
            check("wrap_pc3", 32'(popped[3]), 32'h01);
        end

        // Continuous streaming from address 0.
        redirect_valid = 1'b1; redirect_pc = 7'h00;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Decode stalled: queue fills, requests stop, then drain.
        id_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("stall_count", 32'(dut.count_q), DEPTH);
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Redirect with three slow requests in flight.
        lat = 3;
        for (int i = 0; i < 20 && m_infl.size() != 3; i++) step();
        check("three_in_flight", m_infl.size(), 3);
        redirect_valid = 1'b1; redirect_pc = 7'h20;
        step();
        redirect_valid = 1'b0;
        popped.delete();
        for (int i = 0; i < 20; i++) step();
        check("redir_seen", popped.size() > 0, 1);
        if (popped.size() > 0) check("redir_first_pc", 32'(popped[0]), 32'h20);

        // Redirect colliding with a response, a pop and a ready request.
        lat = 1;
        for (int i = 0; i < 6; i++) step();
        redirect_valid = 1'b1; redirect_pc = 7'h55;
        step();
        redirect_valid = 1'b0;
        check("redir_next_addr", 32'(imem_req_addr), 32'h55);
        for (int i = 0; i < 6; i++) step();

        // Mid-stream reset with two responses outstanding.
        lat = 3;
        for (int i = 0; i < 20 && m_infl.size() != 2; i++) step();
        check("two_in_flight", m_infl.size(), 2);
        rst = 1'b1;
        step();
        rst = 1'b0; imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && mem_pend.size() != 0; i++) step();
        check("strays_drained", mem_pend.size(), 0);
        imem_req_ready = 1'b1;
        popped.delete();
        for (int i = 0; i < 15; i++) step();
        check("rst_seen", popped.size() > 0, 1);
        if (popped.size() > 0) check("rst_first_pc", 32'(popped[0]), 32'(RST_PC));

        // Randomized traffic with occasional redirects.
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom % 4) != 0;
            id_ready       = ($urandom % 3) != 0;
            lat            = 1 + ($urandom % 4);
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc    = 7'($urandom);
            step();
        end
        redirect_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
